sprite_blitter: RTL and testbench

//  Drains 48-bit render commands from the VGA render queue (the FIFO fed by the HPS decoder).

---
 rtl/sprite_blitter_if.sv | 38 +++
 rtl/sprite_blitter.sv | 179 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// ---------------------------------------------------------------------------
// sprite_blitter_if
//   Bus bundle around the sprite blitter: render-queue read side, image
//   memory read port and frame-buffer write port.
//   master : the blitter (pops the queue, drives memory address, writes pixels)
//   slave  : the environment (queue, image memory, frame-buffer writer)
// Signals
//   q_empty   render queue empty; q_dout valid (show-ahead) when 0
//   q_dout    48-bit command {id[7:0], x[9:0], y[9:0], base[19:0]}
//   q_pop     one-cycle pop strobe
//   img_addr  image memory address; data returned on img_dout next cycle
//   img_dout  image memory read data, RGB 8:8:8
//   fb_we     frame-buffer write request, held until fb_ready
//   fb_addr   frame-buffer linear address y*FB_W + x
//   fb_data   pixel RGB
//   fb_ready  frame buffer accepts on fb_we && fb_ready
// ---------------------------------------------------------------------------
interface sprite_blitter_if;
  logic        q_empty;
  logic [47:0] q_dout;
  logic        q_pop;
  logic [19:0] img_addr;
  logic [23:0] img_dout;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_ready;

  modport master (
    input  q_empty, q_dout, img_dout, fb_ready,
    output q_pop, img_addr, fb_we, fb_addr, fb_data
  );

  modport slave (
    output q_empty, q_dout, img_dout, fb_ready,
    input  q_pop, img_addr, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
//   Drains render commands from the render queue and copies one fixed-size
//   sprite per command from image memory to the frame-buffer write port,
//   one pixel at a time (read, wait for data, write). Pixels falling off the
//   right or bottom screen edge are skipped. A command with id 8'hFF marks
//   end of frame and produces a one-cycle frame_done pulse.
//
// Optional feature (compile-time macro SPRITE_COLOR_KEY_EN):
//   defined   -> pixels equal to COLOR_KEY are skipped like clipped pixels
//   undefined -> every on-screen pixel is written; COLOR_KEY is unused
//
// Ports
//   clk50      system clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   clear      synchronous abort: drop current sprite, return to IDLE
//   bus        sprite_blitter_if.master (queue, image memory, frame buffer)
//   frame_done one-cycle pulse on an end-of-frame command
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module sprite_blitter #(
  parameter int          FB_W      = 640,
  parameter int          FB_H      = 480,
  parameter int          SPRITE_W  = 32,
  parameter int          SPRITE_H  = 32,
  parameter logic [23:0] COLOR_KEY = 24'hFF00FF
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic             clear,
  sprite_blitter_if.master bus,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);
  localparam logic [10:0]   FB_W_L   = 11'(FB_W);
  localparam logic [10:0]   FB_H_L   = 11'(FB_H);
  localparam logic [18:0]   FB_W_A   = 19'(FB_W);
  localparam logic [19:0]   SPR_W_A  = 20'(SPRITE_W);
  localparam logic [7:0]    EOF_ID   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_EOF,
    S_RD,
    S_WT,
    S_WR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command and walk position
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [19:0]   r_base;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [23:0]   r_pix;

  logic [10:0] w_px;
  logic [10:0] w_py;
  logic        w_clipped;
  logic        w_keyed;
  logic        w_write;
  logic        w_advance;
  logic        w_last;

  // Screen coordinates are formed one bit wider than x/y so a sprite placed
  // near the edge cannot wrap back onto the visible area.
  assign w_px      = {1'b0, r_x} + 11'(r_col);
  assign w_py      = {1'b0, r_y} + 11'(r_row);
  assign w_clipped = (w_px >= FB_W_L) || (w_py >= FB_H_L);

`ifdef SPRITE_COLOR_KEY_EN
  assign w_keyed = (r_pix == COLOR_KEY);
`else
  // Colour keying is compiled out; COLOR_KEY is parked on a sink net.
  logic [23:0] w_unused_key;
  assign w_unused_key = COLOR_KEY;
  assign w_keyed      = 1'b0;
`endif

  assign w_write   = (r_state == S_WR) && !w_clipped && !w_keyed;
  // A skipped pixel advances at once; a real write waits for acceptance.
  assign w_advance = (r_state == S_WR) && (!w_write || bus.fb_ready);
  assign w_last    = (r_col == COL_LAST) && (r_row == ROW_LAST);

  // Addresses are pure functions of the registered walk state, so they stay
  // frozen while a write is stalled on fb_ready.
  assign bus.img_addr = r_base + 20'(r_row) * SPR_W_A + 20'(r_col);
  assign bus.fb_addr  = 19'(w_py) * FB_W_A + 19'(w_px);
  assign bus.fb_data  = r_pix;

  // State register
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      r_state <= w_state_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    bus.q_pop   = 1'b0;
    bus.fb_we   = 1'b0;
    frame_done  = 1'b0;
    busy        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: if (!bus.q_empty) w_state_nxt = S_POP;
      S_POP: begin
        bus.q_pop   = 1'b1;
        w_state_nxt = (bus.q_dout[47:40] == EOF_ID) ? S_EOF : S_RD;
      end
      S_EOF: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RD: w_state_nxt = S_WT;
      S_WT: w_state_nxt = S_WR;
      S_WR: begin
        bus.fb_we = w_write;
        if (w_advance) w_state_nxt = w_last ? S_IDLE : S_RD;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort wins over everything except reset.
    if (clear) w_state_nxt = S_IDLE;
  end

  // Datapath: command capture, pixel register, column/row walk
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_base <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_pix  <= '0;
    end else if (!clear) begin
      case (r_state)
        S_POP: begin
          r_x    <= bus.q_dout[39:30];
          r_y    <= bus.q_dout[29:20];
          r_base <= bus.q_dout[19:0];
          r_col  <= '0;
          r_row  <= '0;
        end
        S_WT: r_pix <= bus.img_dout;
        S_WR: begin
          if (w_advance) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// ---------------------------------------------------------------------------
// tb_sprite_blitter
//   Self-checking bench for sprite_blitter. A behavioural model expands each
//   render command into the ordered list of frame-buffer writes it must
//   produce; one compare process checks every accepted write, the write
//   hold-while-stalled behaviour, pops and frame pulses. Directed cases pin
//   the model with hand-computed values; a randomized burst follows.
//   Honours SPRITE_COLOR_KEY_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_blitter;

  localparam int          FB_W   = 640;
  localparam int          FB_H   = 480;
  localparam int          SW     = 32;
  localparam int          SH     = 32;
  localparam logic [23:0] KEY    = 24'hFF00FF;
  localparam logic [7:0]  EOF_ID = 8'hFF;
  localparam int          SPRITE_CYCLES = SW * SH * 3 + 1;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  typedef enum {RDY_ALWAYS, RDY_RANDOM, RDY_STALL5} rdy_mode_t;

  logic clk50 = 1'b0;
  logic reset_n;
  logic clear;
  logic frame_done;
  logic busy;

  sprite_blitter_if ifc();

  sprite_blitter #(
    .FB_W     (FB_W),
    .FB_H     (FB_H),
    .SPRITE_W (SW),
    .SPRITE_H (SH),
    .COLOR_KEY(KEY)
  ) dut (
    .clk50     (clk50),
    .reset_n   (reset_n),
    .clear     (clear),
    .bus       (ifc),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #10 clk50 = ~clk50;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] cmdq[$];
  wr_t         expq[$];
  logic [23:0] fb_mem[int];

  logic [23:0] img_salt = '0;
  logic        key_en   = 1'b0;
  logic [19:0] key_addr = '0;
  rdy_mode_t   rdy_mode = RDY_ALWAYS;

  int   cycle = 0, n_pops = 0, n_frames = 0, n_writes = 0;
  int   busy_cycles = 0, stall_count = 0, stall_base = 0;
  int   last_pop_cycle = 0, first_we_lat = -1, frame_lat = -1;
  logic awaiting_we = 1'b0;
  logic [18:0] last_wr_addr = '0;
  logic pop_seen = 1'b0;
  logic prev_stall = 1'b0, prev_fd = 1'b0;
  logic [18:0] prev_addr;
  logic [23:0] prev_data;
  logic [19:0] prev_img;
  wr_t  e;

  int exp_pops = 0, exp_frames = 0;
  int s_pops, s_writes, s_busy, s_frames;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment models ----------------
  function automatic logic [23:0] img_val(input logic [19:0] a);
    if (key_en && a == key_addr) return KEY;
    return 24'(a) ^ img_salt;
  endfunction

  // Synchronous-read image memory: data for img_addr appears next cycle.
  always @(posedge clk50) ifc.img_dout <= img_val(ifc.img_addr);

  task automatic drive_q();
    ifc.q_empty = (cmdq.size() == 0);
    ifc.q_dout  = (cmdq.size() != 0) ? cmdq[0] : '0;
  endtask

  // Render queue: a pop seen during a cycle retires the head after the edge.
  always @(posedge clk50) begin
    #1;
    if (pop_seen && cmdq.size() != 0) begin
      void'(cmdq.pop_front());
      drive_q();
    end
  end

  always @(posedge clk50) begin
    #1;
    case (rdy_mode)
      RDY_ALWAYS: ifc.fb_ready = 1'b1;
      RDY_RANDOM: ifc.fb_ready = ($urandom_range(0, 9) < 7);
      default:    ifc.fb_ready = ((stall_count - stall_base) >= 5);
    endcase
  end

  // Expected writes for one sprite, in raster order.
  task automatic add_model(input logic [9:0] x, input logic [9:0] y, input logic [19:0] base);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int          px;
        int          py;
        logic [23:0] pix;
        bit          keyed;
        px    = int'(x) + c;
        py    = int'(y) + r;
        pix   = img_val(20'(int'(base) + r * SW + c));
        keyed = 1'b0;
`ifdef SPRITE_COLOR_KEY_EN
        keyed = (pix == KEY);
`endif
        if (px < FB_W && py < FB_H && !keyed)
          expq.push_back('{addr: 19'(py * FB_W + px), data: pix});
      end
    end
  endtask

  task automatic push_cmd(input logic [7:0] id, input logic [9:0] x, input logic [9:0] y,
                          input logic [19:0] base, input bit model);
    cmdq.push_back({id, x, y, base});
    drive_q();
    exp_pops++;
    if (id == EOF_ID) exp_frames++;
    else if (model) add_model(x, y, base);
  endtask

  task automatic snap();
    s_pops   = n_pops;
    s_writes = n_writes;
    s_busy   = busy_cycles;
    s_frames = n_frames;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((cmdq.size() != 0 || busy) && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check({name, "_done_in_budget"}, (n < budget), 1);
    check({name, "_model_writes_left"}, expq.size(), 0);
  endtask

  task automatic wait_writes(input int count, input int budget);
    int n;
    n = 0;
    while ((n_writes - s_writes) < count && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check("mid_sprite_reached", (n < budget), 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_q_pop"},      ifc.q_pop,    0);
    check({name, "_fb_we"},      ifc.fb_we,    0);
    check({name, "_frame_done"}, frame_done,   0);
    check({name, "_busy"},       busy,         0);
    check({name, "_img_addr"},   ifc.img_addr, 0);
    check({name, "_fb_addr"},    ifc.fb_addr,  0);
    check({name, "_fb_data"},    ifc.fb_data,  0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk50) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_fd    = 1'b0;
      pop_seen   = 1'b0;
    end else begin
      cycle++;
      pop_seen = ifc.q_pop;
      if (ifc.q_pop) begin
        n_pops++;
        last_pop_cycle = cycle;
        awaiting_we    = 1'b1;
      end
      if (busy) busy_cycles++;
      if (frame_done) begin
        n_frames++;
        frame_lat = cycle - last_pop_cycle;
        check("frame_done_single_cycle", prev_fd, 0);
      end
      prev_fd = frame_done;
      if (ifc.fb_we && awaiting_we) begin
        first_we_lat = cycle - last_pop_cycle;
        awaiting_we  = 1'b0;
      end
      if (prev_stall) begin
        check("stall_hold_fb_we",    ifc.fb_we,    1);
        check("stall_hold_fb_addr",  ifc.fb_addr,  prev_addr);
        check("stall_hold_fb_data",  ifc.fb_data,  prev_data);
        check("stall_hold_img_addr", ifc.img_addr, prev_img);
      end
      if (ifc.fb_we && !ifc.fb_ready) stall_count++;
      if (ifc.fb_we && ifc.fb_ready) begin
        n_writes++;
        last_wr_addr = ifc.fb_addr;
        fb_mem[int'(ifc.fb_addr)] = ifc.fb_data;
        check("write_expected_by_model", (expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("fb_addr", ifc.fb_addr, e.addr);
          check("fb_data", ifc.fb_data, e.data);
        end
      end
      prev_stall = ifc.fb_we && !ifc.fb_ready && !clear;
      prev_addr  = ifc.fb_addr;
      prev_data  = ifc.fb_data;
      prev_img   = ifc.img_addr;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rnd_frames;
    reset_n = 1'b0;
    clear   = 1'b0;
    drive_q();
    repeat (3) @(negedge clk50);
    check_idle_outputs("reset");
    @(posedge clk50);
    #5 reset_n = 1'b1;

    // 1: full sprite at origin, img[i] = i
    snap();
    push_cmd(8'h01, 10'd0, 10'd0, 20'h00000, 1'b1);
    wait_done("t1", SPRITE_CYCLES + 200);
    check("t1_writes",      n_writes - s_writes, 1024);
    check("t1_pops",        n_pops - s_pops, 1);
    check("t1_busy_cycles", busy_cycles - s_busy, 3073);
    check("t1_first_we_latency", first_we_lat, 3);
    check("t1_pix_r0c0",    fb_mem[0], 24'd0);
    check("t1_pix_r1c3",    fb_mem[643], 24'd35);
    check("t1_pix_r31c31",  fb_mem[31 * 640 + 31], 24'd1023);

    // 2: bottom-right corner, only 10x10 visible
    fb_mem.delete();
    img_salt = 24'h5A5A5A;
    snap();
    push_cmd(8'h02, 10'd630, 10'd470, 20'h01234, 1'b1);
    wait_done("t2", SPRITE_CYCLES + 200);
    check("t2_writes",      n_writes - s_writes, 100);
    check("t2_last_addr",   last_wr_addr, 19'd307199);
    check("t2_busy_cycles", busy_cycles - s_busy, 3073);
    check("t2_first_pix",   fb_mem[470 * 640 + 630], 24'h5A486E);
    check("t2_last_pix",    fb_mem[307199], 24'h5A4907);

    // 3: first write stalled for 5 cycles
    img_salt   = 24'h000000;
    stall_base = stall_count;
    rdy_mode   = RDY_STALL5;
    snap();
    push_cmd(8'h03, 10'd100, 10'd50, 20'h00400, 1'b1);
    wait_done("t3", SPRITE_CYCLES + 200);
    check("t3_stall_cycles", stall_count - stall_base, 5);
    check("t3_busy_cycles",  busy_cycles - s_busy, 3078);
    check("t3_writes",       n_writes - s_writes, 1024);
    check("t3_first_pix",    fb_mem[50 * 640 + 100], 24'h000400);
    rdy_mode = RDY_ALWAYS;

    // 4: end-of-frame command
    snap();
    push_cmd(EOF_ID, 10'd5, 10'd5, 20'h00000, 1'b1);
    wait_done("t4", 50);
    check("t4_frames",    n_frames - s_frames, 1);
    check("t4_frame_lat", frame_lat, 1);
    check("t4_writes",    n_writes - s_writes, 0);
    check("t4_pops",      n_pops - s_pops, 1);

    // 5: transparent colour at image address 5
    fb_mem.delete();
    key_en   = 1'b1;
    key_addr = 20'd5;
    rdy_mode = RDY_RANDOM;
    snap();
    push_cmd(8'h05, 10'd0, 10'd0, 20'h00000, 1'b1);
    wait_done("t5", 2 * SPRITE_CYCLES);
    check("t5_pix4", fb_mem[4], 24'd4);
    check("t5_pix6", fb_mem[6], 24'd6);
`ifdef SPRITE_COLOR_KEY_EN
    check("t5_key_skipped", fb_mem.exists(5), 0);
    check("t5_writes", n_writes - s_writes, 1023);
`else
    check("t5_key_written", fb_mem[5], KEY);
    check("t5_writes", n_writes - s_writes, 1024);
`endif
    key_en   = 1'b0;
    rdy_mode = RDY_ALWAYS;

    // 6a: clear mid-sprite with a second command queued
    snap();
    push_cmd(8'h06, 10'd10, 10'd20, 20'h00800, 1'b1);
    push_cmd(8'h07, 10'd300, 10'd200, 20'h01000, 1'b0);
    wait_writes(20, 500);
    @(posedge clk50);
    #1 clear = 1'b1;
    @(posedge clk50);
    #1 clear = 1'b0;
    expq.delete();
    add_model(10'd300, 10'd200, 20'h01000);
    @(negedge clk50);
    check("t6_clear_busy",  busy, 0);
    check("t6_clear_fb_we", ifc.fb_we, 0);
    check("t6_clear_q_pop", ifc.q_pop, 0);
    check("t6_clear_pops",  n_pops - s_pops, 1);
    wait_done("t6a", SPRITE_CYCLES + 200);
    check("t6_clear_total_pops", n_pops - s_pops, 2);

    // 6b: asynchronous reset mid-sprite, then a fresh command
    snap();
    push_cmd(8'h08, 10'd600, 10'd460, 20'h02000, 1'b1);
    wait_writes(30, 2000);
    @(posedge clk50);
    #4 reset_n = 1'b0;
    #1 check_idle_outputs("midreset");
    expq.delete();
    repeat (2) @(negedge clk50);
    @(posedge clk50);
    #5 reset_n = 1'b1;
    snap();
    push_cmd(8'h09, 10'd5, 10'd5, 20'h03000, 1'b1);
    wait_done("t6b", SPRITE_CYCLES + 200);
    check("t6_reset_pops",   n_pops - s_pops, 1);
    check("t6_reset_writes", n_writes - s_writes, 1024);

    // 7: randomized back-to-back commands, random fb_ready
    rdy_mode   = RDY_RANDOM;
    img_salt   = 24'($urandom);
    key_en     = 1'b1;
    key_addr   = 20'($urandom);
    rnd_frames = 0;
    snap();
    for (int i = 0; i < 6; i++) begin
      logic [7:0]  id;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [19:0] base;
      id   = ($urandom_range(0, 5) == 0) ? EOF_ID : 8'($urandom_range(0, 254));
      x    = $urandom_range(0, 1) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(580, 660));
      y    = $urandom_range(0, 1) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(420, 500));
      base = $urandom_range(0, 3) == 0 ? 20'hFFFF0 : 20'($urandom);
      if (i == 0) key_addr = base + 20'($urandom_range(0, SW * SH - 1));
      if (id == EOF_ID) rnd_frames++;
      push_cmd(id, x, y, base, 1'b1);
    end
    wait_done("t7", 6 * 2 * SPRITE_CYCLES);
    check("t7_pops",   n_pops - s_pops, 6);
    check("t7_frames", n_frames - s_frames, rnd_frames);
    check("total_pops",   n_pops, exp_pops);
    check("total_frames", n_frames, exp_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
